// File: rtl/hsiao_39_32_pkg.sv
// Shared Hsiao (39,32) SEC-DED definitions: widths, H-matrix row masks and the check-bit function.
// The decoder uses the same row masks for its syndrome.
package hsiao_39_32_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 7;
    localparam int CW_W   = 39;

    // Row r selects the data bits XORed into check bit C[r].
    localparam logic [DATA_W-1:0] H_ROW0 = 32'h2C02_21FF;
    localparam logic [DATA_W-1:0] H_ROW1 = 32'h13E5_101F;
    localparam logic [DATA_W-1:0] H_ROW2 = 32'hC06C_89E1;
    localparam logic [DATA_W-1:0] H_ROW3 = 32'h7D9C_4422;
    localparam logic [DATA_W-1:0] H_ROW4 = 32'hA2BB_C244;
    localparam logic [DATA_W-1:0] H_ROW5 = 32'h8B50_3E88;
    localparam logic [DATA_W-1:0] H_ROW6 = 32'h5403_FF10;

    function automatic logic [CHK_W-1:0] hsiao_chk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c[0] = ^(d & H_ROW0);
        c[1] = ^(d & H_ROW1);
        c[2] = ^(d & H_ROW2);
        c[3] = ^(d & H_ROW3);
        c[4] = ^(d & H_ROW4);
        c[5] = ^(d & H_ROW5);
        c[6] = ^(d & H_ROW6);
        return c;
    endfunction

endpackage

// File: rtl/hsiao_39_32_enc_pipe_if.sv
// Valid/ready stream bundle used on both sides of the encoder pipe.
interface hsiao_39_32_enc_pipe_if #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/hsiao_39_32_chk_gen.sv
// Combinational 32-to-7 Hsiao check-bit generator over the shared row masks.
module hsiao_39_32_chk_gen
    import hsiao_39_32_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  chk
);
    assign chk = hsiao_chk(data);
endmodule

// File: rtl/hsiao_39_32_enc_pipe.sv
// Pipelined Hsiao (39,32) encoder, 1 or 2 register stages, codeword = {chk, data}.
// Optional error injection mask port when HSIAO_ENC_ERR_INJECT_EN is defined.
module hsiao_39_32_enc_pipe
    import hsiao_39_32_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef HSIAO_ENC_ERR_INJECT_EN
    input  logic [CW_W-1:0]        inj_mask,
`endif
    hsiao_39_32_enc_pipe_if.slave  in_bus,
    hsiao_39_32_enc_pipe_if.master out_bus,
    output logic [CNT_W-1:0]       word_cnt
);

    logic [CW_W-1:0] mask_in;
`ifdef HSIAO_ENC_ERR_INJECT_EN
    assign mask_in = inj_mask;
`else
    assign mask_in = '0;
`endif

    if (PIPE_STAGES == 2) begin : g_two
        logic              v1;
        logic [DATA_W-1:0] d1;
        logic [CHK_W-1:0]  p_lo;
        logic [CHK_W-1:0]  p_hi;
        logic [CHK_W-1:0]  p1_lo;
        logic [CHK_W-1:0]  p1_hi;
        logic [CW_W-1:0]   m1;
        logic              v2;
        logic [CW_W-1:0]   cw2;
        logic              adv2;

        // Partial parities per data half keep the stage-1 XOR depth short.
        hsiao_39_32_chk_gen u_chk_lo (.data({16'h0000, in_bus.data[15:0]}), .chk(p_lo));
        hsiao_39_32_chk_gen u_chk_hi (.data({in_bus.data[31:16], 16'h0000}), .chk(p_hi));

        assign adv2         = ~v2 | out_bus.ready;
        assign in_bus.ready = ~v1 | adv2;

        always_ff @(posedge clk) begin
            if (rst) begin
                v1    <= 1'b0;
                d1    <= '0;
                p1_lo <= '0;
                p1_hi <= '0;
                m1    <= '0;
                v2    <= 1'b0;
                cw2   <= '0;
            end else begin
                if (in_bus.ready) begin
                    v1 <= in_bus.valid;
                    if (in_bus.valid) begin
                        d1    <= in_bus.data;
                        p1_lo <= p_lo;
                        p1_hi <= p_hi;
                        m1    <= mask_in;
                    end
                end
                if (adv2) begin
                    v2 <= v1;
                    if (v1) cw2 <= {p1_lo ^ p1_hi, d1} ^ m1;
                end
            end
        end

        assign out_bus.valid = v2;
        assign out_bus.data  = cw2;
    end else if (PIPE_STAGES == 1) begin : g_one
        logic             v;
        logic [CW_W-1:0]  cw;
        logic [CHK_W-1:0] chk;

        hsiao_39_32_chk_gen u_chk (.data(in_bus.data), .chk(chk));

        assign in_bus.ready = ~v | out_bus.ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                v  <= 1'b0;
                cw <= '0;
            end else if (in_bus.ready) begin
                v <= in_bus.valid;
                if (in_bus.valid) cw <= {chk, in_bus.data} ^ mask_in;
            end
        end

        assign out_bus.valid = v;
        assign out_bus.data  = cw;
    end else begin : g_bad
        $error("hsiao_39_32_enc_pipe: PIPE_STAGES must be 1 or 2");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (in_bus.valid && in_bus.ready && !(&word_cnt)) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hsiao_39_32_enc_pipe.sv
// Self-checking bench: two encoder instances (2-stage/16-bit count, 1-stage/4-bit count).
module tb_hsiao_39_32_enc_pipe;

    typedef struct {
        logic [31:0] d;
        logic [38:0] cw;
    } vec_t;

    logic        clk;
    logic        rst       [2];
    logic [31:0] in_data   [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [38:0] out_cw    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] word_cnt_a;
    logic [3:0]  word_cnt_b;

    int n_chk  = 0;
    int n_fail = 0;
    int pipe_n [2] = '{2, 1};

    int row_bits [7][14] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8, 13, 17, 26, 27, 29},
        '{0, 1, 2, 3, 4, 12, 16, 18, 21, 22, 23, 24, 25, 28},
        '{0, 5, 6, 7, 8, 11, 15, 18, 19, 21, 22, 30, 31, -1},
        '{1, 5, 10, 14, 18, 19, 20, 23, 24, 26, 27, 28, 29, 30},
        '{2, 6, 9, 14, 15, 16, 17, 19, 20, 21, 23, 25, 29, 31},
        '{3, 7, 9, 10, 11, 12, 13, 20, 22, 24, 25, 27, 31, -1},
        '{4, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 26, 28, 30}
    };

    hsiao_39_32_enc_pipe_if #(.W(32)) ia_in  ();
    hsiao_39_32_enc_pipe_if #(.W(39)) ia_out ();
    hsiao_39_32_enc_pipe_if #(.W(32)) ib_in  ();
    hsiao_39_32_enc_pipe_if #(.W(39)) ib_out ();

    assign ia_in.data   = in_data[0];
    assign ia_in.valid  = in_valid[0];
    assign in_ready[0]  = ia_in.ready;
    assign out_cw[0]    = ia_out.data;
    assign out_valid[0] = ia_out.valid;
    assign ia_out.ready = out_ready[0];

    assign ib_in.data   = in_data[1];
    assign ib_in.valid  = in_valid[1];
    assign in_ready[1]  = ib_in.ready;
    assign out_cw[1]    = ib_out.data;
    assign out_valid[1] = ib_out.valid;
    assign ib_out.ready = out_ready[1];

    hsiao_39_32_enc_pipe #(.PIPE_STAGES(2), .CNT_W(16)) dut_a (
        .clk      (clk),
        .rst      (rst[0]),
`ifdef HSIAO_ENC_ERR_INJECT_EN
        .inj_mask (39'h0),
`endif
        .in_bus   (ia_in),
        .out_bus  (ia_out),
        .word_cnt (word_cnt_a)
    );

    hsiao_39_32_enc_pipe #(.PIPE_STAGES(1), .CNT_W(4)) dut_b (
        .clk      (clk),
        .rst      (rst[1]),
`ifdef HSIAO_ENC_ERR_INJECT_EN
        .inj_mask (39'h0),
`endif
        .in_bus   (ib_in),
        .out_bus  (ib_out),
        .word_cnt (word_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] ref_cw(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int r = 0; r < 7; r++)
            for (int j = 0; j < 14; j++)
                if (row_bits[r][j] >= 0) c[r] = c[r] ^ d[row_bits[r][j]];
        return {c, d};
    endfunction

    function automatic logic [6:0] syndrome(input logic [38:0] cw);
        logic [6:0] s;
        for (int r = 0; r < 7; r++) begin
            s[r] = cw[32 + r];
            for (int j = 0; j < 14; j++)
                if (row_bits[r][j] >= 0) s[r] = s[r] ^ cw[row_bits[r][j]];
        end
        return s;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int k);
        in_valid[k]  = 1'b0;
        in_data[k]   = 'x;
        out_ready[k] = 1'b1;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
    endtask

    task automatic send_one(input int k, input logic [31:0] d, input logic [38:0] exp);
        int lat;
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        in_data[k]   = d;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_data[k]  = 'x;
        lat = 1;
        while (!out_valid[k] && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(pipe_n[k]));
        check("table_cw", 64'(out_cw[k]), 64'(exp));
        @(posedge clk); #1;
    endtask

    // mode 0: fixed stall of out_ready on cycles 3..6; mode 1: random traffic
    task automatic run_stream(input int k, input int nwords, input int mode, output int n_out);
        logic [38:0] expq[$];
        logic [38:0] hold_cw;
        logic [31:0] cur;
        logic        cur_valid;
        logic        prev_stall;
        int sent, cyc, budget;
        sent = 0; cyc = 0; n_out = 0;
        cur_valid = 1'b0; prev_stall = 1'b0; cur = '0; hold_cw = '0;
        budget = nwords * 10 + 50;
        while ((sent < nwords || expq.size() != 0) && cyc < budget) begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid[k]), 64'd1);
                check("hold_cw", 64'(out_cw[k]), 64'(hold_cw));
            end
            out_ready[k] = (mode == 0) ? !(cyc >= 3 && cyc <= 6) : ($urandom_range(0, 3) != 0);
            if (!cur_valid && sent < nwords) begin
                if (mode == 0 || $urandom_range(0, 4) != 0) begin
                    cur_valid = 1'b1;
                    cur = (mode == 0) ? 32'h1000_0000 + 32'(sent) * 32'h0101_0101 : $urandom;
                end
            end
            in_valid[k] = cur_valid;
            in_data[k]  = cur_valid ? cur : 'x;
            #1;
            check("in_ready", 64'(in_ready[k]),
                  64'(out_ready[k] || (expq.size() < pipe_n[k])));
            if (out_valid[k] && out_ready[k]) begin
                if (expq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_out: got %h expected no output", out_cw[k]);
                end else begin
                    check("stream_cw", 64'(out_cw[k]), 64'(expq.pop_front()));
                    if (mode == 1) check("syndrome", 64'(syndrome(out_cw[k])), 64'd0);
                end
                n_out++;
            end
            if (in_valid[k] && in_ready[k]) begin
                expq.push_back(ref_cw(cur));
                sent++;
                cur_valid = 1'b0;
            end
            prev_stall = out_valid[k] && !out_ready[k];
            hold_cw    = out_cw[k];
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_done", 64'(sent == nwords && expq.size() == 0), 64'd1);
        in_valid[k]  = 1'b0;
        in_data[k]   = 'x;
        out_ready[k] = 1'b1;
    endtask

    vec_t tbl [6];

    initial begin
        int n_out;
        logic seen;

        tbl[0] = '{d: 32'h0000_0000, cw: 39'h00_0000_0000};
        tbl[1] = '{d: 32'h0000_0001, cw: 39'h07_0000_0001};
        tbl[2] = '{d: 32'hFFFF_FFFF, cw: 39'h24_FFFF_FFFF};
        tbl[3] = '{d: 32'h0000_0002, cw: 39'h0B_0000_0002};
        tbl[4] = '{d: 32'h8000_0000, cw: 39'h34_8000_0000};
        tbl[5] = '{d: 32'h0001_0000, cw: 39'h52_0001_0000};

        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 'x; out_ready[k] = 1'b1; rst[k] = 1'b1;
        end
        @(posedge clk); #1;
        do_reset(0);
        do_reset(1);

        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 64'(out_valid[k]), 64'd0);
            check("rst_out_cw", 64'(out_cw[k]), 64'd0);
            check("rst_in_ready", 64'(in_ready[k]), 64'd1);
        end
        check("rst_cnt_a", 64'(word_cnt_a), 64'd0);
        check("rst_cnt_b", 64'(word_cnt_b), 64'd0);

        send_one(0, 32'h0000_0000, 39'h00_0000_0000);
        check("cnt_after_one", 64'(word_cnt_a), 64'd1);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 6; i++)
                send_one(k, tbl[i].d, tbl[i].cw);

        do_reset(0);
        run_stream(0, 8, 0, n_out);
        check("stall_n_out", 64'(n_out), 64'd8);
        check("stall_cnt", 64'(word_cnt_a), 64'd8);

        run_stream(0, 4000, 1, n_out);
        check("rand_a_n_out", 64'(n_out), 64'd4000);
        run_stream(1, 2000, 1, n_out);
        check("rand_b_n_out", 64'(n_out), 64'd2000);

        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hAAAA_0001;
        @(posedge clk); #1;
        in_data[0] = 32'hAAAA_0002;
        @(posedge clk); #1;
        check("pre_rst_full", 64'(out_valid[0]), 64'd1);
        in_data[0] = 32'hBBBB_0003;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        in_valid[0] = 1'b0;
        in_data[0]  = 'x;
        check("midrst_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_cnt", 64'(word_cnt_a), 64'd0);
        check("midrst_cw", 64'(out_cw[0]), 64'd0);
        out_ready[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | out_valid[0];
            @(posedge clk); #1;
        end
        check("midrst_no_emit", 64'(seen), 64'd0);

        do_reset(1);
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            in_data[1] = $urandom;
            @(posedge clk); #1;
            check("sat_cnt", 64'(word_cnt_b), 64'((i < 15) ? i : 15));
            check("sat_in_ready", 64'(in_ready[1]), 64'd1);
        end
        in_valid[1] = 1'b0;
        in_data[1]  = 'x;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sat_hold", 64'(word_cnt_b), 64'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hsiao_39_32_enc_pipe.md
Name: hsiao_39_32_enc_pipe

Overview:
Pipelined Hsiao SEC-DED encoder; the write-side stage directly upstream of the 39/32 SEC-DED decoder. Accepts 32-bit data words over a valid/ready handshake. Computes 7 check bits with the same H-matrix rows the decoder's syndrome uses. Emits a 39-bit codeword {C[6:0], D[31:0]} (data at [31:0], checks at [38:32]) on a registered valid/ready output toward memory or the decoder.

Parameters:
PIPE_STAGES, 2, register stages between IN and OUT; legal values 1 or 2 only; other values must fail elaboration.
CNT_W, 16, width of the saturating accepted-word counter.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous reset, active high.
IN_DATA  input  32  data word to encode.
IN_VALID  input  1  IN_DATA is valid.
IN_READY  output  1  block accepts IN_DATA this cycle.
OUT_CW  output  39  codeword {C[6:0], data[31:0]}.
OUT_VALID  output  1  OUT_CW is valid.
OUT_READY  input  1  downstream accepts OUT_CW this cycle.
WORD_CNT  output  CNT_W  count of accepted input words; saturates at all-ones.

Behaviour:
- Clocking: one clock CLK. Reset RST is synchronous and active-high.
- Check equations (XOR of data bits D):
  - C0 = D0,1,2,3,4,5,6,7,8,13,17,26,27,29
  - C1 = D0,1,2,3,4,12,16,18,21,22,23,24,25,28
  - C2 = D0,5,6,7,8,11,15,18,19,21,22,30,31
  - C3 = D1,5,10,14,18,19,20,23,24,26,27,28,29,30
  - C4 = D2,6,9,14,15,16,17,19,20,21,23,25,29,31
  - C5 = D3,7,9,10,11,12,13,20,22,24,25,27,31
  - C6 = D4,8,9,10,11,12,13,14,15,16,17,26,28,30
- Pipeline structure:
  - PIPE_STAGES=2: stage 1 registers the data plus 14 partial parities, one per row: XOR of that row's terms in D[15:0] and XOR of its terms in D[31:16]. Stage 2 combines the partials and registers OUT_CW.
  - PIPE_STAGES=1: the single stage registers the full codeword.
- Latency: accepted word appears on OUT_VALID PIPE_STAGES cycles after the accept edge, absent stalls.
- Handshake:
  - Transfer occurs when VALID & READY on a rising edge.
  - Each stage s holds v_s. It advances when ~v_s or the next stage takes its content.
  - IN_READY = ~v1 | advance1. This is a combinational path from OUT_READY; no skid buffer.
  - While OUT_VALID & ~OUT_READY, OUT_CW and OUT_VALID hold stable.
  - Bubbles collapse: a stalled full stage 2 does not block stage 1 if stage 1 is empty.
- Throughput: one word per cycle when OUT_READY is held high.
- Counter: WORD_CNT increments on every input transfer and holds at 2^CNT_W-1.
- Reset values: all v_s=0, OUT_VALID=0, OUT_CW=0, WORD_CNT=0. IN_READY=1 in the first cycle after reset.
- Reset mid-operation: in-flight words are discarded, with no partial output. An input handshake in the reset cycle is ignored and not counted.
- Simultaneous in/out transfer with the pipe full: the input is accepted and the output retired in the same edge; occupancy is unchanged.
- X on IN_DATA with IN_VALID=0 must not propagate to the OUT_VALID logic.

Optional Feature:
Macro HSIAO_ENC_ERR_INJECT_EN. When defined:
- Adds input INJ_MASK[38:0], sampled together with IN_DATA on accept and carried down the pipe.
- OUT_CW = encoded codeword XOR the carried mask.
- Purpose: deliberately inject single-bit or double-bit errors for decoder verification.

When undefined: the port is absent, and OUT_CW is always a clean codeword.

Decomposition:
- Shared package hsiao_39_32_pkg holds:
  - constants DATA_W=32, CHK_W=7, CW_W=39;
  - the 7 H-matrix row masks as 32-bit localparams (H_ROW0..H_ROW6), for reuse by the decoder;
  - a function computing check bits from data.
- One sub-module: hsiao_39_32_chk_gen, a combinational 32-to-7 generator over the package masks, instantiated once. For PIPE_STAGES=2 it is instantiated per 16-bit half, with the two results XORed.

Test Plan:
1. Reset, then IN_DATA=32'h0000_0000 with IN_VALID=1 and OUT_READY=1 -> OUT_CW=39'h00_0000_0000 with OUT_VALID after 2 cycles; WORD_CNT=1.
2. IN_DATA=32'h0000_0001 -> OUT_CW=39'h07_0000_0001. IN_DATA=32'hFFFF_FFFF -> OUT_CW=39'h24_FFFF_FFFF.
3. Stream of 8 words with OUT_READY low for cycles 3-6 -> OUT_CW held stable while stalled, IN_READY=0 once both stages are full, no loss or duplication, order preserved, WORD_CNT=8.
4. RST asserted while 2 words are in flight -> the next cycle has OUT_VALID=0 and WORD_CNT=0; neither in-flight word is ever emitted.
5. 10k random words looped through the decoder -> the decoder reports ERR=0 for every word. With HSIAO_ENC_ERR_INJECT_EN, INJ_MASK=1<<k -> SGL=1; with two bits set -> DBL=1.
6. Hold IN_VALID=1 for 2^CNT_W+3 accepts with CNT_W=4 -> WORD_CNT saturates at 4'hF and stays there.
